// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: latches up to MAX_BYTES words on one load pulse and
// serialises them back-to-back with a runtime baud divisor, optional parity and 1/2 stop bits.
module uart_burst_tx #(
    parameter int DBITS      = 8,
    parameter int MAX_BYTES  = 4,
    parameter int CNT_BITS   = 3,
    parameter int DIV_BITS   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic [DIV_BITS-1:0]        baud_div,
    input  logic                       parity_en,
    input  logic                       parity_odd,
    input  logic                       two_stop,
    input  logic                       load,
    input  logic [DBITS*MAX_BYTES-1:0] load_data,
    input  logic [CNT_BITS-1:0]        load_count,
    output logic                       tx,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_BITS-1:0]        bytes_left,
    output logic                       load_err
);

    localparam int PAY_W = DBITS * MAX_BYTES;
    localparam int BIT_W = $clog2(DBITS);
    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [PAY_W-1:0]    payload_q, payload_d;
    logic [DIV_BITS-1:0] div_m1_q, div_m1_d;
    logic [DIV_BITS-1:0] baud_cnt_q, baud_cnt_d;
    logic [OS_W-1:0]     os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_BITS-1:0] left_q, left_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                two_stop_q, two_stop_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tick;
    logic                bit_end;
    logic [DBITS-1:0]    cur_word;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            div_m1_q   <= '0;
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            left_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            div_m1_q   <= div_m1_d;
            baud_cnt_q <= baud_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            left_q     <= left_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        div_m1_d   = div_m1_q;
        baud_cnt_d = baud_cnt_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        left_d     = left_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tx_d       = 1'b1;
        cur_word   = payload_q[DBITS-1:0];
        tick       = (baud_cnt_q == div_m1_q);
        bit_end    = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));

        if (state_q == IDLE) begin
            if (load) begin
                if (load_count == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d    = START;
                    payload_d  = load_data;
                    // Divisors 0 and 1 both collapse to a tick every cycle.
                    div_m1_d   = (baud_div < DIV_BITS'(2)) ? '0 : baud_div - 1'b1;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                    two_stop_d = two_stop;
                    left_d     = (load_count > MAX_CNT) ? MAX_CNT : load_count;
                    baud_cnt_d = '0;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                end
            end
        end else begin
            if (load) begin
                err_d = 1'b1;
            end
            if (tick) begin
                baud_cnt_d = '0;
                os_cnt_d   = os_cnt_q + 1'b1;
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
            end
            if (bit_end) begin
                os_cnt_d = '0;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                    DATA: begin
                        if (bit_cnt_q == BIT_W'(DBITS - 1)) begin
                            state_d   = par_en_q ? PARITY : STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end
                    STOP: begin
                        if (two_stop_q && (bit_cnt_q == '0)) begin
                            bit_cnt_d = BIT_W'(1);
                        end else begin
                            left_d    = left_q - 1'b1;
                            payload_d = payload_q >> DBITS;
                            bit_cnt_d = '0;
                            if (left_q == CNT_BITS'(1)) begin
                                state_d    = IDLE;
                                done_d     = 1'b1;
                                baud_cnt_d = '0;
                            end else begin
                                state_d = START;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // tx is registered from the next state so the pin never glitches between bits.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_word[bit_cnt_d];
            PARITY:  tx_d = (^cur_word) ^ par_odd_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign bytes_left = left_q;
    assign load_err   = err_q;

endmodule
